spi_master_ctrl: RTL
====================

// Module: spi_master_ctrl
// PURPOSE
//  Command-driven SPI master that sits directly upstream of the SPI slave/RAM wrapper.
//  It takes one host command per transaction and serialises it on MOSI under SS_n.
//  For read-data commands it also captures the 8-bit reply from MISO.
//  It returns that byte to the host with a one-cycle valid pulse.
//  Everything runs on the same system clock that the slave samples on: one bit per clk.
// PARAMETERS
//  FRAME_W   10  bits per command frame: {op[1:0], payload[7:0]}
//  DATA_W     8  reply width shifted in from MISO
//  TURN_CYC   2  idle cycles between last frame bit and first sampled MISO bit (>=1)
//  GAP_CYC    1  cycles SS_n held high after a transaction before next accept (>=1)
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  rst        in   1        asynchronous reset, active-high
//  cmd_valid  in   1        host command present
//  cmd_ready  out  1        master can accept a command this cycle
//  cmd_op     in   2        00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  cmd_data   in   8        address or data payload
//  rsp_valid  out  1        one-cycle pulse: rsp_data holds read byte
//  rsp_data   out  8        byte captured from MISO, MSB first
//  busy       out  1        high from accept until SS_n returns high
//  MOSI       out  1        serial data to slave
//  SS_n       out  1        slave select, active-low
//  MISO       in   1        serial data from slave
// BEHAVIOUR
//  Reset (async, any state): SS_n=1, MOSI=0, cmd_ready=0, busy=0, rsp_valid=0.
//   rsp_data=0; FSM->IDLE; all counters 0. cmd_ready rises on first clk after rst deasserts.
//  Clock/reset: one clock domain; reset asynchronous and active-high.
//  FSM states: IDLE, MODE, SHIFT, TURN, READ, GAP.
//  IDLE: SS_n=1, cmd_ready=1. On cmd_valid&&cmd_ready, latch shreg={cmd_op,cmd_data}.
//   Go to MODE; cmd_ready drops the next cycle; busy=1.
//  MODE (1 cycle): SS_n=0, MOSI=op[1], the slave's read/write select bit. Go to SHIFT.
//  SHIFT (FRAME_W cycles): MOSI=shreg[9], shreg shifts left each cycle, bit 9 first.
//   After the last bit: op==11 -> TURN; otherwise -> GAP.
//  TURN (TURN_CYC cycles): SS_n=0, MOSI=0, MISO ignored. Then -> READ.
//  READ (DATA_W cycles): sample MISO each cycle into rxreg LSB, left-shifting, MSB first.
//   On the 8th sample: rsp_data<=assembled byte, rsp_valid=1 for exactly the next cycle.
//   Then -> GAP.
//  GAP (GAP_CYC cycles): SS_n=1, MOSI=0, busy stays high. Then -> IDLE (busy=0).
//  Latency, accept to SS_n rising: write/rd-addr 1+FRAME_W = 11 cycles.
//   Rd-data: 1+FRAME_W+TURN_CYC+DATA_W = 21 cycles at defaults.
//  cmd_* changes while busy are ignored; no queuing, and the host must hold cmd_valid until ready.
//  cmd_valid held high continuously: back-to-back transactions with exactly GAP_CYC SS_n-high cycles.
//  rsp_data holds its value until the next rd-data completes; never updated by other ops.
//  Reset mid-transaction: SS_n rises asynchronously and no rsp_valid is produced.
//   The partial frame is discarded; the slave sees an aborted frame.
//  Counters are sized $clog2(max(FRAME_W,TURN_CYC,DATA_W,GAP_CYC)+1) and never wrap.
//   Each counter is cleared on state entry.
//  Illegal FSM encoding -> IDLE with SS_n=1.
// TESTING
//  1 Reset: rst=1 mid rd-data READ -> SS_n=1, rsp_valid=0 same cycle; cmd_ready=1 one clk after release.
//  2 Write addr op=00, data=8'hA5 -> MOSI seq 0, then 0,0,1,0,1,0,0,1,0,1.
//    SS_n low 11 cycles, then high for 1 cycle.
//  3 Rd-data op=11, slave model drives 8'h3C after 2 turn cycles -> rsp_valid 1 cycle, rsp_data=8'h3C.
//    SS_n low 21 cycles.
//  4 Back-to-back: cmd_valid held with ops 00,01,10,11 -> four frames, each separated by exactly 1 SS_n-high cycle.
//    Only op 11 yields rsp_valid.
//  5 cmd_data toggled while busy -> transmitted frame unchanged; rsp_data retains prior value after write ops.
//  6 Full loop with spi_wrapper: write addr 0x10, write data 0x7E, read addr 0x10, read data -> rsp_data=0x7E.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: command-driven SPI master that shifts one bit per system clock.
// Each command is sent as a mode bit plus an {op,payload} frame; rd-data commands also capture a reply byte from MISO.
module spi_master_ctrl #(
   parameter int FRAME_W  = 10,
   parameter int DATA_W   = 8,
   parameter int TURN_CYC = 2,
   parameter int GAP_CYC  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [FRAME_W-3:0] cmd_data,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy,
   output logic               MOSI,
   output logic               SS_n,
   input  logic               MISO,
   output logic [2:0]         state_dbg
);

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // the host keeps cmd_valid/cmd_op/cmd_data stable until that edge.

   localparam int MAX_A = (FRAME_W > TURN_CYC) ? FRAME_W : TURN_CYC;
   localparam int MAX_B = (DATA_W > GAP_CYC) ? DATA_W : GAP_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MODE  = 3'd1,
      S_SHIFT = 3'd2,
      S_TURN  = 3'd3,
      S_READ  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic                rd_q, rd_d;
   logic [DATA_W-1:0]   rxreg_q, rxreg_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                ready_en_q, ready_en_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         rd_q        <= 1'b0;
         rxreg_q     <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         rd_q        <= rd_d;
         rxreg_q     <= rxreg_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         ready_en_q  <= ready_en_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      shreg_d     = shreg_q;
      rd_d        = rd_q;
      rxreg_d     = rxreg_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      ready_en_d  = 1'b1;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      SS_n        = 1'b1;
      MOSI        = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy      = 1'b0;
            cnt_d     = '0;
            cmd_ready = ready_en_q;
         end
         S_MODE: begin
            SS_n    = 1'b0;
            MOSI    = shreg_q[FRAME_W-1];
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            SS_n    = 1'b0;
            MOSI    = shreg_q[FRAME_W-1];
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
            if (cnt_q == SHIFT_LAST) begin
               cnt_d   = '0;
               state_d = rd_q ? S_TURN : S_GAP;
            end
         end
         S_TURN: begin
            SS_n = 1'b0;
            if (cnt_q == TURN_LAST) begin
               cnt_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            SS_n    = 1'b0;
            rxreg_d = {rxreg_q[DATA_W-2:0], MISO};
            if (cnt_q == READ_LAST) begin
               rsp_data_d  = {rxreg_q[DATA_W-2:0], MISO};
               rsp_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               // Accepting in the last gap cycle keeps back-to-back frames exactly GAP_CYC apart.
               cmd_ready = ready_en_q;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            busy    = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      if (cmd_valid && cmd_ready) begin
         shreg_d = {cmd_op, cmd_data};
         rd_d    = &cmd_op;
         cnt_d   = '0;
         state_d = S_MODE;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign state_dbg = state_q;

endmodule
